// File: rtl/burst_master_port_if.sv
// Bundle of device-side and bus-side signals for burst_master_port.
// Handshake semantics: a device request transfers on a rising edge where
// dvalid=1 and dready=1; dack is a one-cycle completion pulse and
// derror/drdata are qualified by it. On the bus, mbreq is held until the
// transaction ends, mbgrant is only sampled while waiting for the bus,
// mwdata is qualified by mvalid and mrdata is qualified by svalid.
interface burst_master_port_if #(
    parameter int ADDR_WIDTH       = 16,
    parameter int DATA_WIDTH       = 8,
    parameter int SLAVE_ADDR_WIDTH = 4,
    parameter int LANES            = 1
);
    logic [DATA_WIDTH-1:0]       dwdata;
    logic [DATA_WIDTH-1:0]       drdata;
    logic [ADDR_WIDTH-1:0]       daddr;
    logic                        dvalid;
    logic                        dready;
    logic                        dmode;
    logic                        dack;
    logic                        derror;
    logic                        mbreq;
    logic                        mbgrant;
    logic [SLAVE_ADDR_WIDTH-1:0] msel;
    logic [LANES-1:0]            mwdata;
    logic [LANES-1:0]            mrdata;
    logic                        mmode;
    logic                        mvalid;
    logic                        svalid;

    modport master (
        input  dwdata, daddr, dvalid, dmode, mbgrant, mrdata, svalid,
        output drdata, dready, dack, derror, mbreq, msel, mwdata, mmode, mvalid
    );

    modport slave (
        output dwdata, daddr, dvalid, dmode, mbgrant, mrdata, svalid,
        input  drdata, dready, dack, derror, mbreq, msel, mwdata, mmode, mvalid
    );
endinterface

// File: rtl/burst_master_port.sv
// Serial burst master: takes one device request, arbitrates for the bus,
// shifts out the in-slave address (and write data) LANES bits per beat,
// LSB-first, then either finishes or collects read data with a wait timeout.
module burst_master_port #(
    parameter int ADDR_WIDTH       = 16,
    parameter int DATA_WIDTH       = 8,
    parameter int SLAVE_ADDR_WIDTH = 4,
    parameter int LANES            = 1,
    parameter int TIMEOUT          = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    burst_master_port_if.master        bus,
    output logic [2:0]                 dbg_state
);
    localparam int MEM_WIDTH  = ADDR_WIDTH - SLAVE_ADDR_WIDTH;
    localparam int ADDR_BEATS = MEM_WIDTH / LANES;
    localparam int DATA_BEATS = DATA_WIDTH / LANES;
    localparam int MAX_BEATS  = (ADDR_BEATS > DATA_BEATS) ? ADDR_BEATS : DATA_BEATS;
    localparam int CNT_MAX    = (MAX_BEATS > TIMEOUT) ? MAX_BEATS : TIMEOUT;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, REQ, ADDR, WDATA, RDATA, DONE} state_t;

    state_t                      state;
    state_t                      state_n;
    logic [SLAVE_ADDR_WIDTH-1:0] sel_q;
    logic [MEM_WIDTH-1:0]        mem_q;     // address shift register, LSB goes out first
    logic [DATA_WIDTH-1:0]       wdata_q;   // write data shift register
    logic [DATA_WIDTH-1:0]       rdata_q;   // read data being assembled
    logic [DATA_WIDTH-1:0]       rdata_n;
    logic [DATA_WIDTH-1:0]       drdata_q;
    logic                        derror_q;
    logic                        mode_q;
    logic [CNT_W-1:0]            beat_cnt;
    logic [CNT_W-1:0]            wait_cnt;
    logic                        last_addr;
    logic                        last_data;
    logic                        wait_expired;

    assign last_addr    = (beat_cnt == CNT_W'(ADDR_BEATS - 1));
    assign last_data    = (beat_cnt == CNT_W'(DATA_BEATS - 1));
    assign wait_expired = !bus.svalid && (wait_cnt == CNT_W'(TIMEOUT - 1));

    // New read beats enter at the top; after all beats the first one sits at the LSBs.
    assign rdata_n = {bus.mrdata, rdata_q[DATA_WIDTH-1:LANES]};

    assign bus.msel   = sel_q;
    assign bus.mmode  = mode_q;
    assign bus.drdata = drdata_q;
    assign bus.derror = derror_q;
    assign dbg_state  = state;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode and per-state bus/device outputs.
    always_comb begin
        state_n    = state;
        bus.dready = 1'b0;
        bus.mbreq  = 1'b0;
        bus.mvalid = 1'b0;
        bus.mwdata = '0;
        bus.dack   = 1'b0;
        case (state)
            IDLE: begin
                bus.dready = 1'b1;
                if (bus.dvalid) state_n = REQ;
            end
            REQ: begin
                bus.mbreq = 1'b1;
                if (bus.mbgrant) state_n = ADDR;
            end
            ADDR: begin
                bus.mbreq  = 1'b1;
                bus.mvalid = 1'b1;
                bus.mwdata = mem_q[LANES-1:0];
                if (last_addr) state_n = mode_q ? WDATA : RDATA;
            end
            WDATA: begin
                bus.mbreq  = 1'b1;
                bus.mvalid = 1'b1;
                bus.mwdata = wdata_q[LANES-1:0];
                if (last_data) state_n = DONE;
            end
            RDATA: begin
                bus.mbreq = 1'b1;
                if ((bus.svalid && last_data) || wait_expired) state_n = DONE;
            end
            DONE: begin
                bus.dack = 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Request latches, shift registers, counters and the held completion result.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q    <= '0;
            mem_q    <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            drdata_q <= '0;
            derror_q <= 1'b0;
            mode_q   <= 1'b0;
            beat_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.dvalid) begin
                        sel_q    <= bus.daddr[ADDR_WIDTH-1 -: SLAVE_ADDR_WIDTH];
                        mem_q    <= bus.daddr[MEM_WIDTH-1:0];
                        wdata_q  <= bus.dwdata;
                        mode_q   <= bus.dmode;
                        rdata_q  <= '0;
                        beat_cnt <= '0;
                        wait_cnt <= '0;
                    end
                end
                ADDR: begin
                    mem_q    <= mem_q >> LANES;
                    beat_cnt <= last_addr ? '0 : beat_cnt + CNT_W'(1);
                end
                WDATA: begin
                    wdata_q  <= wdata_q >> LANES;
                    beat_cnt <= beat_cnt + CNT_W'(1);
                    if (last_data) derror_q <= 1'b0;
                end
                RDATA: begin
                    if (bus.svalid) begin
                        rdata_q  <= rdata_n;
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        wait_cnt <= '0;
                        if (last_data) begin
                            drdata_q <= rdata_n;
                            derror_q <= 1'b0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                        if (wait_expired) begin
                            drdata_q <= '0;
                            derror_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_burst_master_port.sv
// Directed bench for burst_master_port: one default instance (LANES=1,
// TIMEOUT=255) and one with LANES=4, TIMEOUT=10. Expected beats and
// completions go into queues; negedge monitors pop and compare.
module tb_burst_master_port;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] dbg0;
    logic [2:0] dbg1;
    int         n_cmp  = 0;
    int         n_fail = 0;

    burst_master_port_if                if0 ();
    burst_master_port_if #(.LANES(4))   if1 ();

    burst_master_port dut0 (.clk(clk), .rst(rst), .bus(if0), .dbg_state(dbg0));
    burst_master_port #(.LANES(4), .TIMEOUT(10)) dut1 (.clk(clk), .rst(rst), .bus(if1), .dbg_state(dbg1));

    // Expected serial beats and completions {check_data, derror, drdata}.
    logic [0:0] beat0_q[$];
    logic [3:0] beat1_q[$];
    logic [9:0] ack0_q[$];
    logic [9:0] ack1_q[$];
    logic [9:0] e0;
    logic [9:0] e1;

    // Clock and reset.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor for dut0.
    always @(negedge clk) begin
        if (if0.mvalid) begin
            if (beat0_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL dut0 beat: got unexpected beat %0h required none", if0.mwdata);
            end else begin
                check("dut0 beat", if0.mwdata, beat0_q.pop_front());
            end
        end
        if (if0.dack) begin
            if (ack0_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL dut0 dack: got unexpected dack required none");
            end else begin
                e0 = ack0_q.pop_front();
                check("dut0 derror", if0.derror, e0[8]);
                if (e0[9]) check("dut0 drdata", if0.drdata, e0[7:0]);
            end
        end
    end

    // Monitor for dut1.
    always @(negedge clk) begin
        if (if1.mvalid) begin
            if (beat1_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL dut1 beat: got unexpected beat %0h required none", if1.mwdata);
            end else begin
                check("dut1 beat", if1.mwdata, beat1_q.pop_front());
            end
        end
        if (if1.dack) begin
            if (ack1_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL dut1 dack: got unexpected dack required none");
            end else begin
                e1 = ack1_q.pop_front();
                check("dut1 derror", if1.derror, e1[8]);
                if (e1[9]) check("dut1 drdata", if1.drdata, e1[7:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_check0(input string tag);
        check({tag, " dready"}, if0.dready, 1);
        check({tag, " mbreq"},  if0.mbreq, 0);
        check({tag, " mvalid"}, if0.mvalid, 0);
        check({tag, " mwdata"}, if0.mwdata, 0);
        check({tag, " mmode"},  if0.mmode, 0);
        check({tag, " dack"},   if0.dack, 0);
        check({tag, " derror"}, if0.derror, 0);
        check({tag, " msel"},   if0.msel, 0);
        check({tag, " drdata"}, if0.drdata, 0);
    endtask

    // Drivers for dut0: issue request, hold REQ gdly+1 cycles, grant; returns in first ADDR cycle.
    task automatic req0(input logic [15:0] a, input logic [7:0] wd, input logic mode,
                        input int gdly, input logic [3:0] exp_sel);
        int n = 0;
        while (!if0.dready && n < 50) begin tick(); n++; end
        check("dut0 dready", if0.dready, 1);
        if0.daddr = a; if0.dwdata = wd; if0.dmode = mode; if0.dvalid = 1'b1;
        tick();
        if0.dvalid = 1'b0;
        check("dut0 msel", if0.msel, exp_sel);
        check("dut0 mmode", if0.mmode, mode);
        check("dut0 dready in REQ", if0.dready, 0);
        for (int i = 0; i < gdly; i++) begin
            check("dut0 mbreq in REQ", if0.mbreq, 1);
            tick();
        end
        if0.mbgrant = 1'b1;
        tick();
        if0.mbgrant = 1'b0;
    endtask

    task automatic rdata0(input logic [7:0] d, input int gap);
        for (int k = 0; k < 8; k++) begin
            if0.svalid = 1'b0;
            repeat (gap) tick();
            if0.svalid = 1'b1;
            if0.mrdata = d[k];
            tick();
        end
        if0.svalid = 1'b0;
        if0.mrdata = '0;
    endtask

    task automatic wait_ack0(output int n);
        n = 0;
        while (!if0.dack && n < 400) begin tick(); n++; end
        check("dut0 dack seen", if0.dack, 1);
        tick();
    endtask

    task automatic push0(input logic [11:0] abeats, input int nd, input logic [7:0] dbeats);
        for (int k = 0; k < 12; k++) beat0_q.push_back(abeats[k]);
        for (int k = 0; k < nd; k++) beat0_q.push_back(dbeats[k]);
    endtask

    // Drivers for dut1 (4-bit beats).
    task automatic req1(input logic [15:0] a, input logic [7:0] wd, input logic mode,
                        input int gdly, input logic [3:0] exp_sel);
        int n = 0;
        while (!if1.dready && n < 50) begin tick(); n++; end
        check("dut1 dready", if1.dready, 1);
        if1.daddr = a; if1.dwdata = wd; if1.dmode = mode; if1.dvalid = 1'b1;
        tick();
        if1.dvalid = 1'b0;
        check("dut1 msel", if1.msel, exp_sel);
        check("dut1 mmode", if1.mmode, mode);
        for (int i = 0; i < gdly; i++) tick();
        if1.mbgrant = 1'b1;
        tick();
        if1.mbgrant = 1'b0;
    endtask

    task automatic wait_ack1(output int n);
        n = 0;
        while (!if1.dack && n < 400) begin tick(); n++; end
        check("dut1 dack seen", if1.dack, 1);
        tick();
    endtask

    initial begin
        int n;
        if0.dwdata = '0; if0.daddr = '0; if0.dvalid = 1'b0; if0.dmode = 1'b0;
        if0.mbgrant = 1'b0; if0.mrdata = '0; if0.svalid = 1'b0;
        if1.dwdata = '0; if1.daddr = '0; if1.dvalid = 1'b0; if1.dmode = 1'b0;
        if1.mbgrant = 1'b0; if1.mrdata = '0; if1.svalid = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        idle_check0("reset");
        check("reset dut1 dready", if1.dready, 1);
        check("reset dut1 mbreq", if1.mbreq, 0);

        // Write 0x3A5C / 0xA5, grant after 3 cycles; svalid noise must be ignored.
        if0.svalid = 1'b1; if0.mrdata = 1'b1;
        push0(12'b1010_0101_1100, 8, 8'b1010_0101);
        ack0_q.push_back({1'b0, 1'b0, 8'h00});
        req0(16'h3A5C, 8'hA5, 1'b1, 3, 4'h3);
        wait_ack0(n);
        if0.svalid = 1'b0; if0.mrdata = 1'b0;

        // Read 0x1004, slave returns 0x6C with 2-cycle gaps.
        push0(12'b0000_0000_0100, 0, 8'h00);
        ack0_q.push_back({1'b1, 1'b0, 8'h6C});
        req0(16'h1004, 8'h00, 1'b0, 1, 4'h1);
        repeat (12) tick();
        rdata0(8'h6C, 2);
        wait_ack0(n);
        repeat (2) tick();
        check("dut0 drdata hold", if0.drdata, 8'h6C);
        check("dut0 derror hold", if0.derror, 0);

        // Reset during the 5th address beat of a write to 0x7123.
        beat0_q.push_back(1'b1); beat0_q.push_back(1'b1); beat0_q.push_back(1'b0);
        beat0_q.push_back(1'b0); beat0_q.push_back(1'b0);
        req0(16'h7123, 8'h3C, 1'b1, 0, 4'h7);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_check0("mid reset");
        repeat (6) tick();
        check("dut0 beats drained after reset", beat0_q.size(), 0);

        // Read after reset completes normally: 0x1004 returns 0x3B, no gaps.
        push0(12'b0000_0000_0100, 0, 8'h00);
        ack0_q.push_back({1'b1, 1'b0, 8'h3B});
        req0(16'h1004, 8'h00, 1'b0, 0, 4'h1);
        repeat (12) tick();
        rdata0(8'h3B, 0);
        wait_ack0(n);

        // LANES=4 write 0x2ABC / 0xF0: beats C,B,A then 0,F.
        beat1_q.push_back(4'hC); beat1_q.push_back(4'hB); beat1_q.push_back(4'hA);
        beat1_q.push_back(4'h0); beat1_q.push_back(4'hF);
        ack1_q.push_back({1'b0, 1'b0, 8'h00});
        req1(16'h2ABC, 8'hF0, 1'b1, 2, 4'h2);
        wait_ack1(n);

        // LANES=4 read 0x5123 returning 0x9D (beats D then 9).
        beat1_q.push_back(4'h3); beat1_q.push_back(4'h2); beat1_q.push_back(4'h1);
        ack1_q.push_back({1'b1, 1'b0, 8'h9D});
        req1(16'h5123, 8'h00, 1'b0, 0, 4'h5);
        repeat (3) tick();
        if1.svalid = 1'b1; if1.mrdata = 4'hD; tick();
        if1.svalid = 1'b0; tick();
        if1.svalid = 1'b1; if1.mrdata = 4'h9; tick();
        if1.svalid = 1'b0; if1.mrdata = 4'h0;
        wait_ack1(n);

        // Timeout with TIMEOUT=10: dack 10 cycles after RDATA entry, derror=1, drdata=0.
        beat1_q.push_back(4'h0); beat1_q.push_back(4'h0); beat1_q.push_back(4'hF);
        ack1_q.push_back({1'b1, 1'b1, 8'h00});
        req1(16'h8F00, 8'h00, 1'b0, 1, 4'h8);
        repeat (3) tick();
        wait_ack1(n);
        check("dut1 timeout latency", n, 10);
        tick();
        check("dut1 derror hold", if1.derror, 1);
        check("dut1 drdata after timeout", if1.drdata, 0);

        // A following write clears derror at its completion.
        beat1_q.push_back(4'h1); beat1_q.push_back(4'h0); beat1_q.push_back(4'h0);
        beat1_q.push_back(4'hA); beat1_q.push_back(4'h5);
        ack1_q.push_back({1'b0, 1'b0, 8'h00});
        req1(16'h0001, 8'h5A, 1'b1, 0, 4'h0);
        wait_ack1(n);

        repeat (4) tick();
        check("dut0 beat queue empty", beat0_q.size(), 0);
        check("dut0 ack queue empty", ack0_q.size(), 0);
        check("dut1 beat queue empty", beat1_q.size(), 0);
        check("dut1 ack queue empty", ack1_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got no completion required finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/burst_master_port.md
BURST_MASTER_PORT -- requirements
Module: burst_master_port

Interface
REQ-001 ADDR_WIDTH, 16, full device address width.
REQ-002 DATA_WIDTH, 8, data word width.
REQ-003 SLAVE_ADDR_WIDTH, 4, upper address bits selecting the slave; MEM_WIDTH = ADDR_WIDTH-SLAVE_ADDR_WIDTH.
REQ-004 LANES, 1, serial bits per bus beat; MEM_WIDTH and DATA_WIDTH SHALL be multiples of LANES.
REQ-005 TIMEOUT, 255, max consecutive read-wait cycles without svalid (>=1).
REQ-006 clk  input  1  single clock, all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 dwdata  input  DATA_WIDTH  device write data.
REQ-009 drdata  output  DATA_WIDTH  device read data, valid when dack=1 and the transaction was a read.
REQ-010 daddr  input  ADDR_WIDTH  device address.
REQ-011 dvalid  input  1  device request valid.
REQ-012 dready  output  1  port accepts a request.
REQ-013 dmode  input  1  0 = read, 1 = write.
REQ-014 dack  output  1  one-cycle completion pulse.
REQ-015 derror  output  1  read timeout flag, qualified by dack.
REQ-016 mbreq  output  1  bus request to arbiter.
REQ-017 mbgrant  input  1  bus grant from arbiter.
REQ-018 msel  output  SLAVE_ADDR_WIDTH  slave id (addr upper bits) for the decoder.
REQ-019 mwdata  output  LANES  serial address/write-data beat.
REQ-020 mrdata  input  LANES  serial read-data beat.
REQ-021 mmode  output  1  latched mode of the current transaction.
REQ-022 mvalid  output  1  mwdata beat valid.
REQ-023 svalid  input  1  mrdata beat valid.

Function
REQ-024 The FSM SHALL have states IDLE, REQ, ADDR, WDATA, RDATA, DONE; dready SHALL be 1 only in IDLE.
REQ-025 In IDLE, dvalid=1 SHALL latch daddr, dwdata and dmode, and the FSM SHALL enter REQ next cycle; dvalid=0 SHALL keep IDLE and hold the latches.
REQ-026 mbreq SHALL be 1 in REQ, ADDR, WDATA and RDATA, and 0 in IDLE and DONE; msel and mmode SHALL hold the latched values from REQ through DONE.
REQ-027 REQ SHALL wait indefinitely for mbgrant=1, then enter ADDR; grant changes after entering ADDR SHALL be ignored.
REQ-028 ADDR SHALL last exactly MEM_WIDTH/LANES cycles with mvalid=1, driving addr[MEM_WIDTH-1:0] LSB-first, LANES bits per cycle (beat k = addr[k*LANES +: LANES]).
REQ-029 After the last address beat, the FSM SHALL enter WDATA if mode=1, otherwise RDATA.
REQ-030 WDATA SHALL last exactly DATA_WIDTH/LANES cycles with mvalid=1, driving wdata LSB-first, then enter DONE.
REQ-031 mvalid SHALL be 0 outside ADDR and WDATA, and address and data beats SHALL be back-to-back with no gap cycle.
REQ-032 In RDATA, each cycle with svalid=1 SHALL store mrdata into the next LANES bits of rdata, LSB-first; after DATA_WIDTH/LANES stored beats the FSM SHALL enter DONE with derror=0.
REQ-033 The wait counter SHALL clear on every svalid=1 and increment on every svalid=0 cycle in RDATA; reaching TIMEOUT SHALL enter DONE with derror=1 and drdata=0.
REQ-034 DONE SHALL last one cycle with dack=1, then enter IDLE; derror SHALL be 0 for writes.
REQ-035 drdata and derror SHALL hold their values until the next DONE.
REQ-036 svalid and mrdata SHALL be ignored outside RDATA; dvalid SHALL be ignored outside IDLE.
REQ-037 The beat counter SHALL be wide enough for max(MEM_WIDTH, DATA_WIDTH)/LANES and for TIMEOUT, with no wrap inside a phase.

Reset
REQ-038 rst=1 at any clock edge, including mid-transaction, SHALL force IDLE and clear all latches and counters; the next cycle SHALL show dready=1 and mbreq=mvalid=mwdata=mmode=dack=derror=0, msel=0, drdata=0.
REQ-039 A transaction interrupted by reset SHALL NOT produce dack.

Verification
REQ-040 Write, defaults: daddr=0x3A5C, dwdata=0xA5, dmode=1, grant after 3 cycles -> msel=3, 12 address beats 0,0,1,1,1,0,1,0,0,1,0,1, then 8 data beats 1,0,1,0,0,1,0,1, then dack=1, derror=0.
REQ-041 Read, defaults: daddr=0x1004, slave returns 0x6C with svalid gaps of 2 cycles -> dack=1, drdata=0x6C, derror=0, mvalid low during RDATA.
REQ-042 Timeout: TIMEOUT=10, read with svalid never asserted -> dack=1 exactly 10 cycles after RDATA entry, derror=1, drdata=0.
REQ-043 LANES=4: write daddr=0x2ABC, dwdata=0xF0 -> 3 address beats C,B,A then 2 data beats 0,F, total mvalid=5 cycles.
REQ-044 Reset during the 5th address beat -> next cycle IDLE, mbreq=0, mvalid=0, no dack; a following read completes normally.
